// File: rtl/exec_muldiv_pkg.sv
// Shared types for the multiply/divide execution port: op encodings, queue entry,
// divider FSM states and the divider latency helper.
package exec_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX
  } div_state_t;

  // Entry fields are sized for the widest build; narrower builds use the low bits.
  localparam int MAX_XLEN  = 64;
  localparam int MAX_TAG_W = 16;

  localparam int DEFAULT_XLEN = 32;
  localparam int DIV_LATENCY  = DEFAULT_XLEN + 2;

  typedef struct packed {
    logic [MAX_TAG_W-1:0] tag;
    logic [MAX_XLEN-1:0]  data;
    logic                 exc;
  } q_entry_t;

  function automatic int div_latency(input int xlen);
    return xlen + 2;
  endfunction

endpackage

// File: rtl/exec_muldiv_port_if.sv
// Issue-side and writeback-side handshake bundle for exec_muldiv_port.
interface exec_muldiv_port_if
  import exec_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) ();

  logic             valid;
  muldiv_op_t       op;
  logic [TAG_W-1:0] tag;
  logic [XLEN-1:0]  src1;
  logic [XLEN-1:0]  src2;
  logic             ready;

  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [XLEN-1:0]  wb_data;
  logic             wb_exc;
  logic             wb_grant;

  modport master (
    output valid, op, tag, src1, src2, wb_grant,
    input  ready, wb_valid, wb_tag, wb_data, wb_exc
  );

  modport slave (
    input  valid, op, tag, src1, src2, wb_grant,
    output ready, wb_valid, wb_tag, wb_data, wb_exc
  );

endinterface

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider: IDLE -> RUN (XLEN cycles) -> FIX -> IDLE.
// Special cases (divide by zero, signed overflow) keep the same fixed latency.
module muldiv_div_iter
  import exec_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  div_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvs;
  logic [XLEN-1:0]  dvd_saved;
  logic             q_neg, r_neg, rem_sel, div0, ovf;

  logic [XLEN:0]    rem_shift;
  logic             rem_ge;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic [XLEN-1:0]  quo_fix, rem_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else if (flush) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != DIV_IDLE);
    done       = 1'b0;
    case (state)
      DIV_IDLE: if (start) state_next = DIV_RUN;
      DIV_RUN:  if (cnt == LAST_CNT) state_next = DIV_FIX;
      DIV_FIX: begin
        done       = 1'b1;
        state_next = DIV_IDLE;
      end
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Operands are made non-negative up front; signs are reapplied in FIX.
  always_comb begin
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    abs_a     = a_neg ? -dividend : dividend;
    abs_b     = b_neg ? -divisor : divisor;
    rem_shift = {rem, quo[XLEN-1]};
    rem_ge    = (rem_shift >= {1'b0, dvs});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      dvd_saved <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      rem_sel   <= 1'b0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      cnt       <= '0;
      quo       <= abs_a;
      rem       <= '0;
      dvs       <= abs_b;
      dvd_saved <= dividend;
      q_neg     <= a_neg ^ b_neg;
      r_neg     <= a_neg;
      rem_sel   <= is_rem;
      div0      <= (divisor == '0);
      ovf       <= is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    end else if (state == DIV_RUN) begin
      cnt <= cnt + 1'b1;
      quo <= {quo[XLEN-2:0], rem_ge};
      rem <= rem_ge ? XLEN'(rem_shift - {1'b0, dvs}) : rem_shift[XLEN-1:0];
    end
  end

  always_comb begin
    quo_fix = q_neg ? -quo : quo;
    rem_fix = r_neg ? -rem : rem;
    if (div0) begin
      quo_fix = '1;
      rem_fix = dvd_saved;
    end else if (ovf) begin
      quo_fix = dvd_saved;
      rem_fix = '0;
    end
    result = rem_sel ? rem_fix : quo_fix;
  end

endmodule

// File: rtl/exec_muldiv_port.sv
// M-extension execution port: pipelined multiplier, optional iterative divider
// (EXEC_MULDIV_DIV_EN) and a credit-controlled writeback queue.
module exec_muldiv_port
  import exec_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 6,
  parameter int MUL_STAGES = 3,
  parameter int OUT_DEPTH  = 2
) (
  input logic               i_clk,
  input logic               i_rst,
  input logic               i_flush,
  exec_muldiv_port_if.slave bus
);

  // The queue register is the last multiplier stage, so only MUL_STAGES-1 pipe registers exist.
  localparam int PIPE_N = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

  logic accept, mul_issue, is_div_op, ready;
  logic div_busy, div_done;
  q_entry_t div_entry;
  q_entry_t issue_entry;

  logic signed [XLEN:0]       mul_a, mul_b;
  logic signed [2*XLEN+1:0]   mul_prod;

  logic [PIPE_N-1:0] pipe_valid;
  q_entry_t          pipe_entry [PIPE_N];
  logic              mul_push;
  q_entry_t          mul_push_entry;

  q_entry_t         q_mem [OUT_DEPTH];
  logic [PTR_W-1:0] q_wr_ptr, q_rd_ptr;
  logic [CNT_W-1:0] q_count;
  logic             q_push, q_pop, wb_valid;
  q_entry_t         q_push_entry, head;
  int               used;
  logic             unused_bits;

  assign is_div_op = bus.op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign accept    = bus.valid && ready && !i_flush;

  always_comb begin
    mul_a = {1'b0, bus.src1};
    mul_b = {1'b0, bus.src2};
    case (bus.op)
      OP_MULH: begin
        mul_a = {bus.src1[XLEN-1], bus.src1};
        mul_b = {bus.src2[XLEN-1], bus.src2};
      end
      OP_MULHSU: mul_a = {bus.src1[XLEN-1], bus.src1};
      default: ;
    endcase
  end

  // Full product is formed at issue and carried down the pipe; retiming balances the stages.
  assign mul_prod = mul_a * mul_b;

  always_comb begin
    issue_entry = '0;
    issue_entry.tag[TAG_W-1:0] = bus.tag;
    if (bus.op == OP_MUL) begin
      issue_entry.data[XLEN-1:0] = mul_prod[XLEN-1:0];
    end else begin
      issue_entry.data[XLEN-1:0] = mul_prod[2*XLEN-1:XLEN];
    end
`ifndef EXEC_MULDIV_DIV_EN
    if (is_div_op) begin
      issue_entry.data = '0;
      issue_entry.exc  = 1'b1;
    end
`endif
  end

`ifdef EXEC_MULDIV_DIV_EN
  logic             div_start;
  logic [TAG_W-1:0] div_tag;
  logic [XLEN-1:0]  div_result;

  assign mul_issue = accept && !is_div_op;
  assign div_start = accept && is_div_op;

  muldiv_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (i_flush),
    .start     (div_start),
    .is_signed ((bus.op == OP_DIV) || (bus.op == OP_REM)),
    .is_rem    ((bus.op == OP_REM) || (bus.op == OP_REMU)),
    .dividend  (bus.src1),
    .divisor   (bus.src2),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_tag <= '0;
    end else if (div_start) begin
      div_tag <= bus.tag;
    end
  end

  always_comb begin
    div_entry = '0;
    div_entry.tag[TAG_W-1:0]  = div_tag;
    div_entry.data[XLEN-1:0] = div_result;
  end
`else
  assign mul_issue = accept;
  assign div_busy  = 1'b0;
  assign div_done  = 1'b0;
  assign div_entry = '0;
`endif

  generate
    if (MUL_STAGES > 1) begin : g_pipe
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          pipe_valid <= '0;
          for (int i = 0; i < PIPE_N; i++) pipe_entry[i] <= '0;
        end else if (i_flush) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= mul_issue;
          pipe_entry[0] <= issue_entry;
          for (int i = 1; i < PIPE_N; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_entry[i] <= pipe_entry[i-1];
          end
        end
      end
      assign mul_push       = pipe_valid[PIPE_N-1];
      assign mul_push_entry = pipe_entry[PIPE_N-1];
    end else begin : g_no_pipe
      assign pipe_valid     = '0;
      assign pipe_entry[0]  = '0;
      assign mul_push       = mul_issue;
      assign mul_push_entry = issue_entry;
    end
  endgenerate

  // Every accepted op holds a credit until its queue entry is granted, so the queue cannot overflow.
  always_comb begin
    used  = int'(q_count) + $countones(pipe_valid) + (div_busy ? 1 : 0);
    ready = (used < OUT_DEPTH) && !div_busy;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUT_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Multiply and divide completions never coincide, so one push port suffices.
  assign q_push       = mul_push || div_done;
  assign q_push_entry = div_done ? div_entry : mul_push_entry;
  assign q_pop        = bus.wb_grant && wb_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_wr_ptr <= '0;
      q_rd_ptr <= '0;
      q_count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) q_mem[i] <= '0;
    end else if (i_flush) begin
      q_wr_ptr <= '0;
      q_rd_ptr <= '0;
      q_count  <= '0;
    end else begin
      if (q_push) begin
        q_mem[q_wr_ptr] <= q_push_entry;
        q_wr_ptr        <= ptr_inc(q_wr_ptr);
      end
      if (q_pop) q_rd_ptr <= ptr_inc(q_rd_ptr);
      if (q_push && !q_pop) begin
        q_count <= q_count + 1'b1;
      end else if (!q_push && q_pop) begin
        q_count <= q_count - 1'b1;
      end
    end
  end

  assign head         = q_mem[q_rd_ptr];
  assign wb_valid     = (q_count != '0);
  assign bus.ready    = ready;
  assign bus.wb_valid = wb_valid;
  assign bus.wb_tag   = wb_valid ? head.tag[TAG_W-1:0] : '0;
  assign bus.wb_data  = wb_valid ? head.data[XLEN-1:0] : '0;
  assign bus.wb_exc   = wb_valid & head.exc;

  assign unused_bits = ^{head.tag, head.data, mul_prod[2*XLEN+1:2*XLEN]};

endmodule

// File: tb/tb_exec_muldiv_port.sv
// Scoreboard bench for exec_muldiv_port; covers both EXEC_MULDIV_DIV_EN builds.
module tb_exec_muldiv_port;
  import exec_muldiv_pkg::*;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 6;
  localparam int MUL_STAGES = 3;
  localparam int OUT_DEPTH  = 2;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
    logic             exc;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];
  exp_t me;

  exec_muldiv_port_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  exec_muldiv_port #(
    .XLEN(XLEN), .TAG_W(TAG_W), .MUL_STAGES(MUL_STAGES), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every head consumed under grant must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && !flush && bus.wb_valid && bus.wb_grant) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_wb", {58'd0, bus.wb_tag}, 64'hFFFF);
      end else begin
        me = sb.pop_front();
        checkOutput("wb_tag", bus.wb_tag, me.tag);
        checkOutput("wb_data", bus.wb_data, me.data);
        checkOutput("wb_exc", bus.wb_exc, me.exc);
        if (me.cyc >= 0) checkOutput("wb_cycle", cyc, me.cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic applyStimulus(input muldiv_op_t op, input logic [TAG_W-1:0] tag,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] exp_data, input logic exp_exc,
                               input int lat, output int acc);
    exp_t e;
    bit   got = 0;
    acc = -1;
    bus.valid = 1'b1;
    bus.op    = op;
    bus.tag   = tag;
    bus.src1  = a;
    bus.src2  = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        acc    = cyc;
        e.tag  = tag;
        e.data = exp_data;
        e.exc  = exp_exc;
        e.cyc  = (lat < 0) ? -1 : cyc + lat;
        sb.push_back(e);
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.valid = 1'b0;
    if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drainWait();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  task automatic checkReadyLow(input int ncyc);
    int bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.ready) bad++;
      @(posedge clk);
      #1;
    end
    checkOutput("ready_low_during_div", bad, 0);
    @(negedge clk);
    checkOutput("ready_after_div", bus.ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int accepted;
    logic [XLEN-1:0] bp_exp [4];
    bp_exp = '{32'd6, 32'd9, 32'd12, 32'd15};

    bus.valid = 1'b0;
    bus.op = OP_MUL;
    bus.tag = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.wb_grant = 1'b0;
    flush = 1'b0;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_wb_valid", bus.wb_valid, 0);
    checkOutput("reset_ready", bus.ready, 1);
    checkOutput("reset_wb_data", bus.wb_data, 0);
    checkOutput("reset_wb_tag", bus.wb_tag, 0);
    checkOutput("reset_wb_exc", bus.wb_exc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_first_cycle", bus.ready, 1);
    @(posedge clk);
    #1;

    // Multiplies with grant held: each result appears MUL_STAGES cycles after acceptance.
    bus.wb_grant = 1'b1;
    applyStimulus(OP_MUL,    6'd5,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 3, acc);
    applyStimulus(OP_MULHU,  6'd6,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3, acc);
    applyStimulus(OP_MULHSU, 6'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3, acc);
    applyStimulus(OP_MULH,   6'd8,  32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 3, acc);
    applyStimulus(OP_MUL,    6'd9,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3, acc);
    applyStimulus(OP_MULH,   6'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3, acc);
    applyStimulus(OP_MULHU,  6'd11, 32'h80000000, 32'd2,        32'h00000001, 1'b0, 3, acc);
    drainWait();

`ifdef EXEC_MULDIV_DIV_EN
    applyStimulus(OP_DIV,  6'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34, acc);
    checkReadyLow(33);
    applyStimulus(OP_REM,  6'd13, 32'd17, 32'd0, 32'd17, 1'b0, 34, acc);
    checkReadyLow(33);
    applyStimulus(OP_DIVU, 6'd14, 32'd17, 32'd0, 32'hFFFFFFFF, 1'b0, 34, acc);
    checkReadyLow(33);
    applyStimulus(OP_DIV,  6'd15, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34, acc);
    applyStimulus(OP_REM,  6'd16, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34, acc);
    applyStimulus(OP_REMU, 6'd17, 32'd100, 32'd7, 32'd2, 1'b0, 34, acc);
    drainWait();
`else
    applyStimulus(OP_DIVU, 6'd12, 32'd17, 32'd0, 32'd0, 1'b1, 3, acc);
    applyStimulus(OP_REM,  6'd13, 32'd17, 32'd5, 32'd0, 1'b1, 3, acc);
    applyStimulus(OP_DIV,  6'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, 3, acc);
    applyStimulus(OP_MUL,  6'd15, 32'd6, 32'd7, 32'd42, 1'b0, 3, acc);
    drainWait();
`endif

    // Back-pressure: grant low, four offers in a row, only OUT_DEPTH fit.
    bus.wb_grant = 1'b0;
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      bus.valid = 1'b1;
      bus.op    = OP_MUL;
      bus.tag   = TAG_W'(20 + i);
      bus.src1  = XLEN'(i + 2);
      bus.src2  = 32'd3;
      @(negedge clk);
      if (bus.ready) begin
        accepted++;
        sb.push_back('{tag: TAG_W'(20 + i), data: bp_exp[i], exc: 1'b0, cyc: -1});
      end
      @(posedge clk);
      #1;
    end
    bus.valid = 1'b0;
    checkOutput("bp_accepted", accepted, 2);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_ready_full", bus.ready, 0);
    checkOutput("bp_wb_valid_full", bus.wb_valid, 1);
    @(posedge clk);
    #1 bus.wb_grant = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_grant_cycle", bus.ready, 0);
    @(posedge clk);
    #1 bus.wb_grant = 1'b0;
    @(negedge clk);
    checkOutput("bp_credit_returned", bus.ready, 1);
    @(posedge clk);
    #1 bus.wb_grant = 1'b1;
    drainWait();

    // Flush with one result queued and one still in the multiplier.
    bus.wb_grant = 1'b0;
    applyStimulus(OP_MUL, 6'd30, 32'd2, 32'd2, 32'd4, 1'b0, -1, acc);
    applyStimulus(OP_MUL, 6'd31, 32'd3, 32'd3, 32'd9, 1'b0, -1, acc);
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.valid = 1'b1;
    bus.op = OP_MUL;
    bus.tag = 6'd40;
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_wb_valid", bus.wb_valid, 0);
    checkOutput("flush_ready", bus.ready, 1);
    @(posedge clk);
    #1 bus.wb_grant = 1'b1;
    repeat (8) @(posedge clk);
    #1;

`ifdef EXEC_MULDIV_DIV_EN
    applyStimulus(OP_DIVU, 6'd32, 32'd100, 32'd3, 32'd33, 1'b0, -1, acc);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_div_ready", bus.ready, 1);
    checkOutput("flush_div_wb_valid", bus.wb_valid, 0);
    repeat (40) @(posedge clk);
    #1;
`endif

    // Asynchronous reset while a result is waiting in the queue.
    bus.wb_grant = 1'b0;
    applyStimulus(OP_MUL, 6'd33, 32'd5, 32'd5, 32'd25, 1'b0, -1, acc);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_wb_valid", bus.wb_valid, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("async_reset_wb_valid", bus.wb_valid, 0);
    checkOutput("async_reset_ready", bus.ready, 1);
    checkOutput("async_reset_wb_data", bus.wb_data, 0);
    checkOutput("async_reset_wb_tag", bus.wb_tag, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", bus.ready, 1);
    @(posedge clk);
    #1 bus.wb_grant = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    checkOutput("sb_empty_at_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
